// File: rtl/ethernet_test_top.sv
// Atlys Ethernet loopback/debug block: button-triggered GMII test frame, UART-armed
// GMII receive capture that is dumped back over RS-232. Single clock domain.
module ethernet_test_top #(
    parameter int unsigned CLKS_PER_BIT = 100,
    parameter int unsigned CAP_DEPTH    = 64,
    parameter int unsigned PAYLOAD_LEN  = 46
) (
    input  logic       clk_100_pin,
    input  logic [5:0] btn,
    output logic       PhyResetOut_pin,
    input  logic       MII_TX_CLK_pin,
    output logic [7:0] GMII_TXD_pin,
    output logic       GMII_TX_EN_pin,
    output logic       GMII_TX_ER_pin,
    output logic       GMII_TX_CLK_pin,
    input  logic [7:0] GMII_RXD_pin,
    input  logic       GMII_RX_DV_pin,
    input  logic       GMII_RX_ER_pin,
    input  logic       GMII_RX_CLK_pin,
    output logic       MDC_pin,
    inout  wire        MDIO_pin,
    output logic [7:0] leds,
    input  logic [7:0] sw,
    input  logic       rs232_rx,
    output logic       rs232_tx
);

    localparam int unsigned HeaderLen = 22;
    localparam int unsigned FrameLen  = HeaderLen + PAYLOAD_LEN;
    localparam int unsigned AddrW     = $clog2(CAP_DEPTH);
    localparam int unsigned CntW      = AddrW + 1;
    localparam logic [15:0] BitLast   = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HalfLast  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]  GapLast   = 4'd11;
    localparam logic [CntW-1:0] CapFull = CntW'(CAP_DEPTH);

    typedef enum logic [1:0] {TxIdle, TxSend, TxGap} tx_state_t;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;
    typedef enum logic [1:0] {CapIdle, CapArmed, CapCapture, CapDump} cap_state_t;

    // Reset asserts asynchronously from btn[5] and releases synchronously.
    logic       ext_rst_n;
    logic [1:0] rst_sync;
    logic       rst_n;

    assign ext_rst_n = btn[5];

    always_ff @(posedge clk_100_pin or negedge ext_rst_n) begin
        if (!ext_rst_n) rst_sync <= 2'b00;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n           = rst_sync[1];
    assign PhyResetOut_pin = rst_n;
    assign GMII_TX_ER_pin  = 1'b0;
    assign GMII_TX_CLK_pin = clk_100_pin;
    assign MDC_pin         = 1'b0;
    assign MDIO_pin        = 1'bz;

    logic unused_inputs;
    assign unused_inputs = ^{btn[4:1], MII_TX_CLK_pin, GMII_RX_ER_pin, GMII_RX_CLK_pin};

    // Input conditioning
    logic [1:0] btn0_sync;
    logic       btn0_prev;
    logic [7:0] sw_meta;
    logic [7:0] sw_sync;
    logic [1:0] rx_sync;
    logic       rx_prev;
    logic [7:0] rxd_r;
    logic       dv_r;
    logic       dv_prev;

    always_ff @(posedge clk_100_pin or negedge rst_n) begin
        if (!rst_n) begin
            btn0_sync <= 2'b11;
            btn0_prev <= 1'b1;
            sw_meta   <= 8'h00;
            sw_sync   <= 8'h00;
            rx_sync   <= 2'b11;
            rx_prev   <= 1'b1;
            rxd_r     <= 8'h00;
            dv_r      <= 1'b0;
            dv_prev   <= 1'b0;
        end else begin
            btn0_sync <= {btn0_sync[0], btn[0]};
            btn0_prev <= btn0_sync[1];
            sw_meta   <= sw;
            sw_sync   <= sw_meta;
            rx_sync   <= {rx_sync[0], rs232_rx};
            rx_prev   <= rx_sync[1];
            rxd_r     <= GMII_RXD_pin;
            dv_r      <= GMII_RX_DV_pin;
            dv_prev   <= dv_r;
        end
    end

    logic btn_fall;
    logic rx_fall;
    logic dv_rise;

    assign btn_fall = btn0_prev & ~btn0_sync[1];
    assign rx_fall  = rx_prev & ~rx_sync[1];
    assign dv_rise  = dv_r & ~dv_prev;

    // Frame transmitter
    tx_state_t  tx_state;
    logic [7:0] tx_idx;
    logic [3:0] gap_cnt;
    logic [7:0] frame_sw;
    logic [7:0] frame_cnt;
    logic [7:0] frame_byte;

    always_comb begin
        frame_byte = 8'h00;
        if (tx_idx < 8'd7) begin
            frame_byte = 8'h55;
        end else if (tx_idx == 8'd7) begin
            frame_byte = 8'hD5;
        end else if (tx_idx < 8'd14) begin
            frame_byte = 8'hFF;
        end else if (tx_idx < 8'd20) begin
            case (tx_idx)
                8'd15:   frame_byte = 8'h0A;
                8'd16:   frame_byte = 8'h35;
                8'd19:   frame_byte = 8'h01;
                default: frame_byte = 8'h00;
            endcase
        end else if (tx_idx == 8'd20) begin
            frame_byte = 8'h88;
        end else if (tx_idx == 8'd21) begin
            frame_byte = 8'hB5;
        end else if (tx_idx == 8'd22) begin
            frame_byte = frame_sw;
        end else begin
            frame_byte = tx_idx - 8'(HeaderLen);
        end
    end

    always_ff @(posedge clk_100_pin or negedge rst_n) begin
        if (!rst_n) begin
            tx_state       <= TxIdle;
            tx_idx         <= 8'd0;
            gap_cnt        <= 4'd0;
            frame_sw       <= 8'h00;
            frame_cnt      <= 8'd0;
            GMII_TXD_pin   <= 8'h00;
            GMII_TX_EN_pin <= 1'b0;
        end else begin
            case (tx_state)
                TxIdle: begin
                    if (btn_fall) begin
                        frame_sw <= sw_sync;
                        tx_idx   <= 8'd0;
                        tx_state <= TxSend;
                    end
                end
                TxSend: begin
                    if (tx_idx == 8'(FrameLen)) begin
                        GMII_TXD_pin   <= 8'h00;
                        GMII_TX_EN_pin <= 1'b0;
                        frame_cnt      <= frame_cnt + 8'd1;
                        gap_cnt        <= 4'd0;
                        tx_state       <= TxGap;
                    end else begin
                        GMII_TXD_pin   <= frame_byte;
                        GMII_TX_EN_pin <= 1'b1;
                        tx_idx         <= tx_idx + 8'd1;
                    end
                end
                TxGap: begin
                    if (gap_cnt == GapLast) tx_state <= TxIdle;
                    else                    gap_cnt  <= gap_cnt + 4'd1;
                end
                default: tx_state <= TxIdle;
            endcase
        end
    end

    // UART receiver, 8N1
    rx_state_t   rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_valid;

    always_ff @(posedge clk_100_pin or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RxIdle;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RxIdle: begin
                    if (rx_fall) begin
                        rx_cnt   <= 16'd0;
                        rx_state <= RxStart;
                    end
                end
                RxStart: begin
                    if (rx_cnt == HalfLast) begin
                        rx_cnt   <= 16'd0;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_sync[1] ? RxIdle : RxData;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RxData: begin
                    if (rx_cnt == BitLast) begin
                        rx_cnt   <= 16'd0;
                        rx_shift <= {rx_sync[1], rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RxStop;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RxStop: begin
                    if (rx_cnt == BitLast) begin
                        rx_valid <= rx_sync[1];
                        rx_state <= RxIdle;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: rx_state <= RxIdle;
            endcase
        end
    end

    // Capture buffer and dump
    cap_state_t      cap_state;
    logic [CntW-1:0] cap_cnt;
    logic [CntW-1:0] dump_idx;
    logic [9:0]      dump_frame;
    logic [3:0]      dump_bit;
    logic [15:0]     dump_clk;
    logic [7:0]      cap_mem [CAP_DEPTH];
    logic            cap_wr;
    logic [AddrW-1:0] cap_addr;
    logic [7:0]      dump_byte;
    logic            arm_cmd;

    assign arm_cmd   = rx_valid && (rx_shift == 8'h41);
    assign cap_wr    = ((cap_state == CapArmed) && dv_rise) ||
                       ((cap_state == CapCapture) && dv_r && (cap_cnt != CapFull));
    assign cap_addr  = (cap_state == CapArmed) ? '0 : cap_cnt[AddrW-1:0];
    // Byte after the one on the wire; the count byte occupies dump slot 0.
    assign dump_byte = cap_mem[dump_idx[AddrW-1:0]];

    always_ff @(posedge clk_100_pin) begin
        if (cap_wr) cap_mem[cap_addr] <= rxd_r;
    end

    always_ff @(posedge clk_100_pin or negedge rst_n) begin
        if (!rst_n) begin
            cap_state  <= CapIdle;
            cap_cnt    <= '0;
            dump_idx   <= '0;
            dump_frame <= 10'h3FF;
            dump_bit   <= 4'd0;
            dump_clk   <= 16'd0;
            rs232_tx   <= 1'b1;
        end else begin
            case (cap_state)
                CapIdle: begin
                    if (arm_cmd) cap_state <= CapArmed;
                end
                CapArmed: begin
                    if (dv_rise) begin
                        cap_cnt   <= CntW'(1);
                        cap_state <= CapCapture;
                    end
                end
                CapCapture: begin
                    if (!dv_r || (cap_cnt == CapFull)) begin
                        dump_frame <= {1'b1, 8'(cap_cnt), 1'b0};
                        rs232_tx   <= 1'b0;
                        dump_bit   <= 4'd0;
                        dump_clk   <= 16'd0;
                        dump_idx   <= '0;
                        cap_state  <= CapDump;
                    end else begin
                        cap_cnt <= cap_cnt + CntW'(1);
                    end
                end
                CapDump: begin
                    if (dump_clk == BitLast) begin
                        dump_clk <= 16'd0;
                        if (dump_bit == 4'd9) begin
                            if (dump_idx == cap_cnt) begin
                                rs232_tx  <= 1'b1;
                                cap_state <= CapIdle;
                            end else begin
                                // Next start bit follows the stop bit with no gap.
                                dump_frame <= {1'b1, dump_byte, 1'b0};
                                rs232_tx   <= 1'b0;
                                dump_bit   <= 4'd0;
                                dump_idx   <= dump_idx + CntW'(1);
                            end
                        end else begin
                            rs232_tx <= dump_frame[dump_bit + 4'd1];
                            dump_bit <= dump_bit + 4'd1;
                        end
                    end else begin
                        dump_clk <= dump_clk + 16'd1;
                    end
                end
                default: cap_state <= CapIdle;
            endcase
        end
    end

    always_ff @(posedge clk_100_pin or negedge rst_n) begin
        if (!rst_n) begin
            leds <= 8'h00;
        end else begin
            leds <= {frame_cnt[3:0], GMII_TX_EN_pin, cap_state == CapDump,
                     cap_state == CapCapture, cap_state == CapArmed};
        end
    end

endmodule

// File: tb/tb_ethernet_test_top.sv
// Directed-plus-random bench for ethernet_test_top: frame contents, UART arming,
// loopback capture dump and asynchronous reset behaviour.
module tb_ethernet_test_top;

    localparam int CPB = 50;

    logic       clk = 1'b0;
    logic [5:0] btn;
    logic [7:0] sw;
    logic       rs232_rx;
    logic [7:0] rxd_drv;
    logic       dv_drv;
    logic       loop_en;

    logic       phy_rst;
    logic [7:0] txd;
    logic       txen;
    logic       txer;
    logic       txclk;
    logic       mdc;
    wire        mdio;
    logic [7:0] leds;
    logic       rs232_tx;
    logic [7:0] rxd_in;
    logic       dv_in;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_frame [$];
    logic [7:0] got [$];

    always #5 clk = ~clk;

    assign rxd_in = loop_en ? txd : rxd_drv;
    assign dv_in  = loop_en ? txen : dv_drv;

    ethernet_test_top #(
        .CLKS_PER_BIT (CPB),
        .CAP_DEPTH    (64),
        .PAYLOAD_LEN  (46)
    ) dut (
        .clk_100_pin     (clk),
        .btn             (btn),
        .PhyResetOut_pin (phy_rst),
        .MII_TX_CLK_pin  (1'b0),
        .GMII_TXD_pin    (txd),
        .GMII_TX_EN_pin  (txen),
        .GMII_TX_ER_pin  (txer),
        .GMII_TX_CLK_pin (txclk),
        .GMII_RXD_pin    (rxd_in),
        .GMII_RX_DV_pin  (dv_in),
        .GMII_RX_ER_pin  (1'b0),
        .GMII_RX_CLK_pin (1'b0),
        .MDC_pin         (mdc),
        .MDIO_pin        (mdio),
        .leds            (leds),
        .sw              (sw),
        .rs232_rx        (rs232_rx),
        .rs232_tx        (rs232_tx)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected frame assembled field by field.
    task automatic build_frame(input logic [7:0] s);
        logic [7:0] src [6];
        src = '{8'h00, 8'h0A, 8'h35, 8'h00, 8'h00, 8'h01};
        exp_frame.delete();
        repeat (7) exp_frame.push_back(8'h55);
        exp_frame.push_back(8'hD5);
        repeat (6) exp_frame.push_back(8'hFF);
        foreach (src[i]) exp_frame.push_back(src[i]);
        exp_frame.push_back(8'h88);
        exp_frame.push_back(8'hB5);
        exp_frame.push_back(s);
        for (int k = 1; k < 46; k++) exp_frame.push_back(8'(k));
    endtask

    task automatic uart_send(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rs232_rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rs232_rx = b[i];
            cycles(CPB);
        end
        rs232_rx = stop;
        cycles(CPB);
        rs232_rx = 1'b1;
        cycles(CPB);
    endtask

    task automatic uart_get(output logic [7:0] b, output logic ok);
        int t;
        t  = 0;
        ok = 1'b1;
        b  = 8'h00;
        while (rs232_tx !== 1'b0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            ok = 1'b0;
            return;
        end
        cycles(CPB / 2);
        if (rs232_tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycles(CPB);
            b[i] = rs232_tx;
        end
        cycles(CPB);
        if (rs232_tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic press_and_check_frame(input logic [7:0] s, input int hold, input string tag);
        int waited;
        int extra;
        sw = s;
        build_frame(s);
        cycles(5);
        btn[0] = 1'b0;
        waited = 0;
        while (!txen && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_start"}, txen, 1'b1);
        got.delete();
        while (txen && got.size() < 100) begin
            got.push_back(txd);
            @(negedge clk);
        end
        check({tag, "_len"}, got.size(), 68);
        check({tag, "_txd_idle"}, txd, 8'h00);
        for (int i = 0; i < exp_frame.size() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got[i], exp_frame[i]);
        extra = 0;
        for (int c = 0; c < hold; c++) begin
            if (txen) extra++;
            @(negedge clk);
        end
        btn[0] = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (txen) extra++;
            @(negedge clk);
        end
        check({tag, "_single"}, extra, 0);
    endtask

    task automatic burst_and_dump(input int len, input string tag);
        logic [7:0] sent [$];
        logic [7:0] b;
        logic ok;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            dv_drv  = 1'b1;
            rxd_drv = 8'($urandom);
            sent.push_back(rxd_drv);
        end
        @(negedge clk);
        dv_drv = 1'b0;
        uart_get(b, ok);
        check({tag, "_cnt_ok"}, ok, 1'b1);
        check({tag, "_cnt"}, b, 8'(len));
        for (int i = 0; i < len; i++) begin
            uart_get(b, ok);
            check($sformatf("%s_ok%0d", tag, i), ok, 1'b1);
            check($sformatf("%s_b%0d", tag, i), b, sent[i]);
        end
    endtask

    initial begin
        logic [7:0] b;
        logic ok;
        logic [7:0] s;
        int t;
        int lows;

        btn      = 6'h3F;
        sw       = 8'h00;
        rs232_rx = 1'b1;
        rxd_drv  = 8'h00;
        dv_drv   = 1'b0;
        loop_en  = 1'b0;

        // Reset held 20 cycles
        #2;
        btn[5] = 1'b0;
        cycles(20);
        check("rst_txen", txen, 1'b0);
        check("rst_txd", txd, 8'h00);
        check("rst_uart", rs232_tx, 1'b1);
        check("rst_leds", leds, 8'h00);
        check("rst_phy", phy_rst, 1'b0);
        btn[5] = 1'b1;
        cycles(1);
        check("phy_sync_delay", phy_rst, 1'b0);
        cycles(2);
        check("phy_release", phy_rst, 1'b1);
        check("tx_er", txer, 1'b0);
        check("mdc", mdc, 1'b0);
        check("post_rst_leds", leds, 8'h00);

        // Non-'A' command is ignored
        b = 8'($urandom);
        if (b == 8'h41) b = 8'h52;
        uart_send(b, 1'b1);
        check("other_byte_leds", leds, 8'h00);

        // 'A' with bad stop bit does not arm
        uart_send(8'h41, 1'b0);
        check("bad_stop_leds", leds, 8'h00);

        // Glitch shorter than half a bit is a false start
        @(negedge clk);
        rs232_rx = 1'b0;
        cycles(CPB * 2 / 5);
        rs232_rx = 1'b1;
        cycles(3 * CPB);
        check("glitch_leds", leds, 8'h00);

        // Glitch immediately followed by 'A': receiver must be idle again in time
        rs232_rx = 1'b0;
        cycles(CPB * 2 / 5);
        rs232_rx = 1'b1;
        cycles(10);
        uart_send(8'h41, 1'b1);
        check("armed", leds, 8'h01);
        uart_send(8'h41, 1'b1);
        check("armed_again", leds, 8'h01);

        // Frames without loopback
        press_and_check_frame(8'hA5, 440, "fa5");
        check("frame1_leds", leds, 8'h11);
        press_and_check_frame(8'($urandom), 100, "frnd");
        check("frame2_leds", leds, 8'h21);

        // Loopback capture: 64 of the 68 bytes come back, preceded by the count
        s = 8'($urandom);
        sw = s;
        build_frame(s);
        loop_en = 1'b1;
        cycles(5);
        btn[0] = 1'b0;
        cycles(20);
        btn[0] = 1'b1;
        uart_get(b, ok);
        check("loop_cnt_ok", ok, 1'b1);
        check("loop_cnt", b, 8'h40);
        for (int i = 0; i < 64; i++) begin
            uart_get(b, ok);
            check($sformatf("loop_ok%0d", i), ok, 1'b1);
            check($sformatf("loop_b%0d", i), b, exp_frame[i]);
        end
        cycles(CPB);
        check("loop_done_leds", leds, 8'h30);
        loop_en = 1'b0;

        // Random-length direct capture
        uart_send(8'h41, 1'b1);
        check("arm2", leds[2:0], 3'b001);
        burst_and_dump($urandom_range(1, 20), "burst");
        cycles(CPB);
        check("burst_done_leds", leds[2:0], 3'b000);

        // Reset in the middle of a frame
        sw = 8'($urandom);
        cycles(5);
        btn[0] = 1'b0;
        t = 0;
        while (!txen && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("midframe_started", txen, 1'b1);
        cycles(20);
        btn[0] = 1'b1;
        btn[5] = 1'b0;
        #1;
        check("midframe_rst_txen", txen, 1'b0);
        check("midframe_rst_txd", txd, 8'h00);
        cycles(20);
        btn[5] = 1'b1;
        cycles(5);
        press_and_check_frame(8'($urandom), 100, "fpost");
        check("post_rst_count", leds[7:4], 4'd1);

        // Reset in the middle of a dump
        uart_send(8'h41, 1'b1);
        check("arm3", leds[2:0], 3'b001);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dv_drv  = 1'b1;
            rxd_drv = 8'($urandom);
        end
        @(negedge clk);
        dv_drv = 1'b0;
        t = 0;
        while (rs232_tx !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("dump_started", rs232_tx, 1'b0);
        cycles(5);
        btn[5] = 1'b0;
        #1;
        check("middump_rst_tx", rs232_tx, 1'b1);
        check("middump_rst_leds", leds, 8'h00);
        cycles(10);
        btn[5] = 1'b1;
        lows = 0;
        for (int c = 0; c < 20 * CPB; c++) begin
            if (rs232_tx !== 1'b1) lows++;
            @(negedge clk);
        end
        check("middump_no_resume", lows, 0);
        check("middump_idle_leds", leds, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
